// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter datapath and its neighbours.
package iir_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned Q_FRAC = 14;

    // Signed Q2.14 sample as emitted by opti_top.
    typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/iir_sat_cnt.sv
// Saturating up-counter with synchronous clear; an increment in the clear cycle leaves 1.
module iir_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] One = W'(1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= inc ? One : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + One;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/iir_out_fifo.sv
// Output elasticity buffer for opti_top: no back-pressure to the filter, overflowing samples
// are dropped, counted and flagged.
module iir_out_fifo
    import iir_pkg::*;
#(
    parameter int unsigned DATA_W = iir_pkg::DATA_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     valid_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    input  logic                     clr_ovf,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q, level_q;
    logic              overflow_q;
    logic              empty, full, push, pop, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop   = !empty && ready_in;
    // A pop frees the slot on the same edge, so a full FIFO still accepts the write.
    assign push  = valid_in && (!full || pop);
    assign drop  = valid_in && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            if (push && !pop) begin
                level_q <= level_q + PtrOne;
            end else if (pop && !push) begin
                level_q <= level_q - PtrOne;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    iir_sat_cnt #(
        .W (CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop),
        .clr   (clr_ovf),
        .cnt   (drop_cnt)
    );

    // Gate the head so stale or never-written memory is not visible when empty.
    assign data_out  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign valid_out = !empty;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_iir_out_fifo.sv
// Directed self-checking bench for iir_out_fifo (default geometry plus a DEPTH=4, CNT_W=4 copy).
module tb_iir_out_fifo;
    import iir_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic        valid_in, ready_in, clr_ovf;
    logic [15:0] data_out;
    logic        valid_out, overflow;
    logic [15:0] drop_cnt;
    logic [4:0]  level;

    logic        valid_b, ready_b, clr_b;
    logic [15:0] data_out_b;
    logic        valid_out_b, overflow_b;
    logic [3:0]  drop_cnt_b;
    logic [2:0]  level_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iir_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (16),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .clr_ovf   (clr_ovf),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    iir_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (4),
        .CNT_W  (4)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_b),
        .data_out  (data_out_b),
        .valid_out (valid_out_b),
        .ready_in  (ready_b),
        .clr_ovf   (clr_b),
        .overflow  (overflow_b),
        .drop_cnt  (drop_cnt_b),
        .level     (level_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] vec [8];
    logic [15:0] smp;

    initial begin
        vec = '{16'h4000, 16'hC000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'hEDCC};
        rst_n = 1'b0; data_in = '0; valid_in = 0; ready_in = 0; clr_ovf = 0;
        valid_b = 0; ready_b = 0; clr_b = 0;
        repeat (2) tick();
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: fill 8 with ready low, then drain in order
        for (int i = 0; i < 8; i++) begin
            data_in = vec[i]; valid_in = 1; tick();
            if (i == 0) chk("t1_first_latency", 32'(data_out), 32'h4000);
        end
        valid_in = 0;
        chk("t1_level8", 32'(level), 32'd8);
        chk("t1_valid", 32'(valid_out), 32'd1);
        ready_in = 1;
        for (int i = 0; i < 8; i++) begin
            chk("t1_order", 32'(data_out), 32'(vec[i]));
            tick();
        end
        ready_in = 0;
        chk("t1_level0", 32'(level), 32'd0);
        chk("t1_valid0", 32'(valid_out), 32'd0);
        chk("t1_data0", 32'(data_out), 32'd0);

        // 2: 20 writes into 16 entries
        for (int i = 0; i < 20; i++) begin
            data_in = 16'h0100 + 16'(i); valid_in = 1; tick();
        end
        valid_in = 0;
        chk("t2_level", 32'(level), 32'd16);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_drop_cnt", 32'(drop_cnt), 32'd4);

        // 3: full with simultaneous push and pop
        ready_in = 1;
        for (int j = 0; j < 5; j++) begin
            chk("t3_head", 32'(data_out), 32'h0100 + 32'(j));
            data_in = 16'hA000 + 16'(j); valid_in = 1; tick();
            chk("t3_level", 32'(level), 32'd16);
        end
        valid_in = 0;
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd4);
        for (int k = 0; k < 16; k++) begin
            smp = (k < 11) ? 16'h0105 + 16'(k) : 16'hA000 + 16'(k - 11);
            chk("t3_drain", 32'(data_out), 32'(smp));
            tick();
        end
        ready_in = 0;
        chk("t3_level0", 32'(level), 32'd0);
        clr_ovf = 1; tick(); clr_ovf = 0;
        chk("t3_clr_ovf", 32'(overflow), 32'd0);
        chk("t3_clr_cnt", 32'(drop_cnt), 32'd0);

        // 4: full-rate stream, wraps pointers many times
        ready_in = 1;
        for (int i = 0; i < 2048; i++) begin
            data_in = 16'(i * 32'h9E37); valid_in = 1; tick();
            chk("t4_data", 32'(data_out), 32'(16'(i * 32'h9E37)));
            chk("t4_level", 32'(level), 32'd1);
        end
        valid_in = 0; tick();
        ready_in = 0;
        chk("t4_level0", 32'(level), 32'd0);
        chk("t4_no_drop", 32'(drop_cnt), 32'd0);
        chk("t4_no_ovf", 32'(overflow), 32'd0);

        // 5: saturation on the 4-bit counter, then clear coinciding with a drop
        for (int i = 0; i < 24; i++) begin
            data_in = 16'h3000 + 16'(i); valid_b = 1; tick();
            if (i == 17) chk("t5_cnt14", 32'(drop_cnt_b), 32'd14);
        end
        chk("t5_sat", 32'(drop_cnt_b), 32'd15);
        chk("t5_level", 32'(level_b), 32'd4);
        chk("t5_head", 32'(data_out_b), 32'h3000);
        clr_b = 1; tick();
        chk("t5_clr_drop_ovf", 32'(overflow_b), 32'd1);
        chk("t5_clr_drop_cnt", 32'(drop_cnt_b), 32'd1);
        valid_b = 0; tick(); clr_b = 0;
        chk("t5_clr_ovf", 32'(overflow_b), 32'd0);
        chk("t5_clr_cnt", 32'(drop_cnt_b), 32'd0);

        // 6: asynchronous reset mid-operation
        for (int i = 0; i < 10; i++) begin
            data_in = 16'h0700 + 16'(i); valid_in = 1; tick();
        end
        valid_in = 0;
        chk("t6_level10", 32'(level), 32'd10);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_level", 32'(level), 32'd0);
        chk("t6_async_valid", 32'(valid_out), 32'd0);
        chk("t6_async_data", 32'(data_out), 32'd0);
        tick();
        rst_n = 1'b1;
        data_in = 16'h5A5A; valid_in = 1; tick(); valid_in = 0;
        chk("t6_level1", 32'(level), 32'd1);
        chk("t6_head", 32'(data_out), 32'h5A5A);
        chk("t6_valid", 32'(valid_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
